tl_a_arbiter: RTL and testbench
===============================

TL_A_ARBITER -- requirements
Module: tl_a_arbiter

Interface
REQ-001 Parameters: ADDR_W 32 (address width); DATA_W 64 (beat width); NREQ 2 (requesters, fixed).
REQ-002 clock  in  1  sole clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; low clears all state immediately.
REQ-004 rq_a_valid[i] / rq_a_ready[i]  in/out  1 each  requester i A-channel handshake, i in {0,1}.
REQ-005 rq_a_opcode[i], rq_a_param[i], rq_a_size[i]  in  3 each  requester A fields.
REQ-006 rq_a_source[i]  in  2  requester-local source ID.
REQ-007 rq_a_address[i]  in  ADDR_W; rq_a_mask[i]  in  8; rq_a_data[i]  in  DATA_W.
REQ-008 a_valid/a_ready  out/in  1; a_opcode, a_param, a_size  out  3; a_source  out  3; a_address  out  ADDR_W; a_mask  out  8; a_data  out  DATA_W  shared tile A channel.
REQ-009 d_valid/d_ready  in/out  1; d_opcode, d_size, d_source  in  3; d_param, d_sink  in  2; d_data  in  DATA_W  shared tile D channel.
REQ-010 rq_d_valid[i]/rq_d_ready[i]  out/in  1; rq_d_source[i]  out  2; remaining rq_d fields  out  same widths as d_*.

Function
REQ-011 States: IDLE, HOLD, BURST; reset state IDLE.
REQ-012 IDLE: grant = highest-priority valid requester; prio_q=0 gives req0 priority, prio_q=1 gives req1 priority; no valid -> a_valid=0.
REQ-013 a_valid = granted rq_a_valid; all a_* fields = granted requester fields, except a_source = {grant index, rq_a_source}.
REQ-014 rq_a_ready[i] = a_ready AND grant==i AND state permits; non-granted ready = 0.
REQ-015 IDLE, a_valid=1, a_ready=0 -> HOLD, grant latched; a_* held stable until handshake (TileLink stability rule).
REQ-016 Beat count: data opcodes 0-3 (Put/Arith/Logical) with size>3 -> 2^(size-3) beats; all other cases 1 beat; max 16, 4-bit counter.
REQ-017 First-beat handshake of single-beat message -> IDLE; of multi-beat -> BURST, remaining = beats-1, grant latched.
REQ-018 BURST: each handshake decrements remaining; handshake at remaining==1 -> IDLE; no other requester served mid-burst.
REQ-019 prio_q updates on first-beat handshake to the non-granted index (round-robin); unchanged otherwise.
REQ-020 Both valid in IDLE -> prio_q winner; loser waits exactly one message.
REQ-021 Zero combinational-to-register latency: first beat may fire in the same cycle rq_a_valid rises.
REQ-022 D routing stateless: rq_d_valid[i] = d_valid AND d_source[2]==i; rq_d_source = d_source[1:0]; d_ready = rq_d_ready[d_source[2]].
REQ-023 A and D paths independent; simultaneous A grant and D response to same requester both proceed.

Reset
REQ-024 reset low: state IDLE, prio_q 0, remaining 0, latched grant 0; a_valid and all rq_a_ready 0 while asserted.
REQ-025 Reset mid-burst abandons burst; no residual lock after release.
REQ-026 First arbitration allowed on first rising edge after release.

Structure
REQ-027 Shared package: state enum, opcode constants (PutFullData..LogicalData), beat-count function, source-width constants.
REQ-028 One sub-module natural: tl_beat_counter (size/opcode -> beat count, decrementing counter, last-beat flag).
REQ-029 No clock gating; single always_ff block for state, prio_q, counter, grant.

Verification
REQ-030 Both valid, Get size 3, a_ready=1, reset prio -> req0 wins, a_source=3'b0xx; next cycle req1 wins, a_source=3'b1xx.
REQ-031 req1 PutFullData size 6 (8 beats) with req0 valid -> 8 consecutive req1 beats, req0 ready=0 throughout, IDLE after beat 8.
REQ-032 req0 valid, a_ready=0 for 5 cycles, req1 raises valid cycle 2 -> a_* stable at req0 values all 5 cycles, req0 fires first.
REQ-033 d_source=3'b101, d_valid=1 -> rq_d_valid[1]=1, rq_d_source[1]=2'b01, rq_d_valid[0]=0, d_ready follows rq_d_ready[1].
REQ-034 reset low during beat 3 of 4-beat burst -> a_valid 0 immediately; after release, other requester's message granted normally.
REQ-035 PutFullData size 2 -> 1 beat, immediate IDLE; Get size 6 -> 1 beat.

Source files
------------

// File: rtl/tl_a_arbiter_pkg.sv
// Shared types and helpers for the two-requester TileLink A-channel arbiter.
package tl_a_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StHold  = 2'd1,
    StBurst = 2'd2
  } arb_state_e;

  localparam logic [2:0] OpPutFullData    = 3'd0;
  localparam logic [2:0] OpPutPartialData = 3'd1;
  localparam logic [2:0] OpArithmeticData = 3'd2;
  localparam logic [2:0] OpLogicalData    = 3'd3;
  localparam logic [2:0] OpGet            = 3'd4;

  localparam int unsigned ReqSrcW  = 2;
  localparam int unsigned TileSrcW = 3;
  localparam int unsigned BeatCntW = 4;

  // Beats in a message: data-carrying opcodes wider than one 8-byte beat span 2^(size-3) beats.
  function automatic logic [4:0] beat_count(input logic [2:0] opcode, input logic [2:0] size);
    if (opcode <= OpLogicalData && size > 3'd3) begin
      return 5'd1 << (size - 3'd3);
    end
    return 5'd1;
  endfunction

endpackage

// File: rtl/tl_beat_counter.sv
// Beat-count decode and remaining-beat arithmetic for the arbiter's burst counter.
module tl_beat_counter
  import tl_a_arbiter_pkg::*;
(
  input  logic [2:0]          i_opcode,
  input  logic [2:0]          i_size,
  input  logic [BeatCntW-1:0] i_remaining,
  output logic                o_multi,
  output logic [BeatCntW-1:0] o_first_rem,
  output logic [BeatCntW-1:0] o_rem_next,
  output logic                o_last
);

  logic [4:0] w_beats;

  assign w_beats     = beat_count(i_opcode, i_size);
  assign o_multi     = (w_beats != 5'd1);
  // 16 beats wraps to 0 in the low nibble, so minus one yields 15 as required.
  assign o_first_rem = w_beats[BeatCntW-1:0] - 4'd1;
  assign o_rem_next  = i_remaining - 4'd1;
  assign o_last      = (i_remaining == 4'd1);

endmodule

// File: rtl/tl_a_arbiter.sv
// Round-robin arbiter merging two TileLink A channels, with burst locking and stateless D routing.
module tl_a_arbiter
  import tl_a_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREQ   = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NREQ-1:0]                i_rq_a_valid,
  output logic [NREQ-1:0]                o_rq_a_ready,
  input  logic [NREQ-1:0][2:0]           i_rq_a_opcode,
  input  logic [NREQ-1:0][2:0]           i_rq_a_param,
  input  logic [NREQ-1:0][2:0]           i_rq_a_size,
  input  logic [NREQ-1:0][ReqSrcW-1:0]   i_rq_a_source,
  input  logic [NREQ-1:0][ADDR_W-1:0]    i_rq_a_address,
  input  logic [NREQ-1:0][7:0]           i_rq_a_mask,
  input  logic [NREQ-1:0][DATA_W-1:0]    i_rq_a_data,
  output logic                           o_a_valid,
  input  logic                           i_a_ready,
  output logic [2:0]                     o_a_opcode,
  output logic [2:0]                     o_a_param,
  output logic [2:0]                     o_a_size,
  output logic [TileSrcW-1:0]            o_a_source,
  output logic [ADDR_W-1:0]              o_a_address,
  output logic [7:0]                     o_a_mask,
  output logic [DATA_W-1:0]              o_a_data,
  input  logic                           i_d_valid,
  output logic                           o_d_ready,
  input  logic [2:0]                     i_d_opcode,
  input  logic [1:0]                     i_d_param,
  input  logic [2:0]                     i_d_size,
  input  logic [TileSrcW-1:0]            i_d_source,
  input  logic [1:0]                     i_d_sink,
  input  logic [DATA_W-1:0]              i_d_data,
  output logic [NREQ-1:0]                o_rq_d_valid,
  input  logic [NREQ-1:0]                i_rq_d_ready,
  output logic [NREQ-1:0][2:0]           o_rq_d_opcode,
  output logic [NREQ-1:0][1:0]           o_rq_d_param,
  output logic [NREQ-1:0][2:0]           o_rq_d_size,
  output logic [NREQ-1:0][ReqSrcW-1:0]   o_rq_d_source,
  output logic [NREQ-1:0][1:0]           o_rq_d_sink,
  output logic [NREQ-1:0][DATA_W-1:0]    o_rq_d_data
);

  arb_state_e          r_state;
  logic                r_prio;
  logic                r_grant;
  logic [BeatCntW-1:0] r_rem;

  logic                w_idle_pick;
  logic                w_grant;
  logic                w_has_grant;
  logic                w_fire;
  logic                w_multi;
  logic [BeatCntW-1:0] w_first_rem;
  logic [BeatCntW-1:0] w_rem_next;
  logic                w_last;

  // Grant selection: priority pick while idle, latched grant while a message is in flight.
  always_comb begin
    w_idle_pick = r_prio;
    if (!i_rq_a_valid[r_prio]) begin
      w_idle_pick = ~r_prio;
    end
    w_grant     = (r_state == StIdle) ? w_idle_pick : r_grant;
    w_has_grant = (r_state != StIdle) | (|i_rq_a_valid);
  end

  // Shared A channel mux; reset gating keeps a_valid and readies low while reset is held.
  always_comb begin
    o_a_valid    = i_rst_n & i_rq_a_valid[w_grant];
    o_rq_a_ready = {i_rst_n & w_has_grant & i_a_ready & w_grant,
                    i_rst_n & w_has_grant & i_a_ready & ~w_grant};
    o_a_opcode   = i_rq_a_opcode[w_grant];
    o_a_param    = i_rq_a_param[w_grant];
    o_a_size     = i_rq_a_size[w_grant];
    o_a_source   = {w_grant, i_rq_a_source[w_grant]};
    o_a_address  = i_rq_a_address[w_grant];
    o_a_mask     = i_rq_a_mask[w_grant];
    o_a_data     = i_rq_a_data[w_grant];
  end

  assign w_fire = o_a_valid & i_a_ready;

  tl_beat_counter u_beat_counter (
    .i_opcode    (o_a_opcode),
    .i_size      (o_a_size),
    .i_remaining (r_rem),
    .o_multi     (w_multi),
    .o_first_rem (w_first_rem),
    .o_rem_next  (w_rem_next),
    .o_last      (w_last)
  );

  // Arbitration FSM: state, round-robin pointer, remaining-beat counter and latched grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_prio  <= 1'b0;
      r_grant <= 1'b0;
      r_rem   <= '0;
    end else begin
      unique case (r_state)
        StIdle, StHold: begin
          if (w_fire) begin
            r_prio  <= ~w_grant;
            r_grant <= w_grant;
            if (w_multi) begin
              r_state <= StBurst;
              r_rem   <= w_first_rem;
            end else begin
              r_state <= StIdle;
            end
          end else if (o_a_valid) begin
            r_state <= StHold;
            r_grant <= w_grant;
          end
        end
        StBurst: begin
          if (w_fire) begin
            if (w_last) begin
              r_state <= StIdle;
              r_rem   <= '0;
            end else begin
              r_rem <= w_rem_next;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // D responses route on the top source bit; no state involved.
  always_comb begin
    o_rq_d_valid  = {i_d_valid & i_d_source[2], i_d_valid & ~i_d_source[2]};
    o_d_ready     = i_rq_d_ready[i_d_source[2]];
    o_rq_d_opcode = {NREQ{i_d_opcode}};
    o_rq_d_param  = {NREQ{i_d_param}};
    o_rq_d_size   = {NREQ{i_d_size}};
    o_rq_d_source = {NREQ{i_d_source[1:0]}};
    o_rq_d_sink   = {NREQ{i_d_sink}};
    o_rq_d_data   = {NREQ{i_d_data}};
  end

endmodule

// File: tb/tb_tl_a_arbiter.sv
// Self-checking bench for tl_a_arbiter: directed corner cases, D routing table, random vs model.
module tb_tl_a_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]        rq_a_valid, rq_a_ready;
  logic [1:0][2:0]   rq_a_opcode, rq_a_param, rq_a_size;
  logic [1:0][1:0]   rq_a_source;
  logic [1:0][31:0]  rq_a_address;
  logic [1:0][7:0]   rq_a_mask;
  logic [1:0][63:0]  rq_a_data;
  logic              a_valid, a_ready;
  logic [2:0]        a_opcode, a_param, a_size, a_source;
  logic [31:0]       a_address;
  logic [7:0]        a_mask;
  logic [63:0]       a_data;
  logic              d_valid, d_ready;
  logic [2:0]        d_opcode, d_size, d_source;
  logic [1:0]        d_param, d_sink;
  logic [63:0]       d_data;
  logic [1:0]        rq_d_valid, rq_d_ready;
  logic [1:0][2:0]   rq_d_opcode, rq_d_size;
  logic [1:0][1:0]   rq_d_param, rq_d_source, rq_d_sink;
  logic [1:0][63:0]  rq_d_data;

  tl_a_arbiter #(.ADDR_W(32), .DATA_W(64), .NREQ(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rq_a_valid(rq_a_valid), .o_rq_a_ready(rq_a_ready),
    .i_rq_a_opcode(rq_a_opcode), .i_rq_a_param(rq_a_param), .i_rq_a_size(rq_a_size),
    .i_rq_a_source(rq_a_source), .i_rq_a_address(rq_a_address), .i_rq_a_mask(rq_a_mask),
    .i_rq_a_data(rq_a_data),
    .o_a_valid(a_valid), .i_a_ready(a_ready), .o_a_opcode(a_opcode), .o_a_param(a_param),
    .o_a_size(a_size), .o_a_source(a_source), .o_a_address(a_address), .o_a_mask(a_mask),
    .o_a_data(a_data),
    .i_d_valid(d_valid), .o_d_ready(d_ready), .i_d_opcode(d_opcode), .i_d_param(d_param),
    .i_d_size(d_size), .i_d_source(d_source), .i_d_sink(d_sink), .i_d_data(d_data),
    .o_rq_d_valid(rq_d_valid), .i_rq_d_ready(rq_d_ready), .o_rq_d_opcode(rq_d_opcode),
    .o_rq_d_param(rq_d_param), .o_rq_d_size(rq_d_size), .o_rq_d_source(rq_d_source),
    .o_rq_d_sink(rq_d_sink), .o_rq_d_data(rq_d_data)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the channel, how many beats of the current message have gone.
  int   m_prio, m_owner, m_sent, m_total;
  int   e_g, e_beats;
  logic e_fire, e_av;

  function automatic int msg_beats(input logic [2:0] op, input logic [2:0] size);
    if (op < 3'd4 && size > 3'd3) return 2 ** (int'(size) - 3);
    return 1;
  endfunction

  task automatic model_reset();
    m_prio = 0; m_owner = -1; m_sent = 0; m_total = 0;
  endtask

  task automatic model_check();
    int g, s;
    logic any;
    if (m_owner >= 0) begin
      g = m_owner; any = 1'b1;
    end else begin
      any = |rq_a_valid;
      g = rq_a_valid[m_prio] ? m_prio : 1 - m_prio;
    end
    e_av = rq_a_valid[g];
    chk("a_valid", a_valid, e_av);
    chk("rq_a_ready", rq_a_ready, (any && a_ready) ? (2'b01 << g) : 2'b00);
    if (e_av) begin
      chk("a_source", a_source, {g[0], rq_a_source[g]});
      chk("a_address", a_address, rq_a_address[g]);
      chk("a_data", a_data, rq_a_data[g]);
      chk("a_fields", {a_opcode, a_param, a_size, a_mask},
          {rq_a_opcode[g], rq_a_param[g], rq_a_size[g], rq_a_mask[g]});
    end
    s = int'(d_source[2]);
    chk("rq_d_valid", rq_d_valid, d_valid ? (2'b01 << s) : 2'b00);
    chk("rq_d_source", rq_d_source[s], d_source[1:0]);
    chk("d_ready", d_ready, rq_d_ready[s]);
    chk("rq_d_bcast", {rq_d_data[1-s], rq_d_opcode[1-s]}, {d_data, d_opcode});
    e_g = g;
    e_fire = e_av && a_ready;
    e_beats = msg_beats(rq_a_opcode[g], rq_a_size[g]);
  endtask

  task automatic model_update();
    if (e_fire) begin
      if (m_sent == 0) begin
        m_total = e_beats;
        m_prio = 1 - e_g;
      end
      m_sent++;
      if (m_sent == m_total) begin
        m_owner = -1; m_sent = 0;
      end else begin
        m_owner = e_g;
      end
    end else if (e_av && m_owner < 0) begin
      m_owner = e_g;
    end
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic cycle();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset a_valid", a_valid, 1'b0);
    chk("reset rq_a_ready", rq_a_ready, 2'b00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] op, input logic [2:0] sz,
                         input logic [1:0] src, input logic [31:0] addr);
    rq_a_valid[i]   = v;
    rq_a_opcode[i]  = op;
    rq_a_size[i]    = sz;
    rq_a_source[i]  = src;
    rq_a_address[i] = addr;
    rq_a_param[i]   = 3'd0;
    rq_a_mask[i]    = 8'hff;
    rq_a_data[i]    = {$urandom, $urandom};
  endtask

  typedef struct {
    logic       dv;
    logic [2:0] ds;
    logic [1:0] rdy;
    logic [1:0] e_v;
    logic [1:0] e_src;
    logic       e_rdy;
  } dvec_t;

  dvec_t dt[6];

  initial begin
    rst_n = 1'b0;
    a_ready = 1'b0;
    d_valid = 1'b0; d_source = '0; d_opcode = '0; d_size = '0; d_param = '0; d_sink = '0;
    d_data = '0; rq_d_ready = '0;
    set_req(0, 1'b0, 3'd4, 3'd3, 2'd0, 32'h0);
    set_req(1, 1'b0, 3'd4, 3'd3, 2'd0, 32'h0);
    model_reset();
    @(negedge clk);

    // Reset gating with traffic present, then both requesters race with Get size 3.
    set_req(0, 1'b1, 3'd4, 3'd3, 2'd1, 32'h100);
    set_req(1, 1'b1, 3'd4, 3'd3, 2'd2, 32'h200);
    a_ready = 1'b1;
    do_reset();
    #1 chk("rr first winner", a_source, 3'b001);
    cycle();
    #1 chk("rr second winner", a_source, 3'b110);
    cycle();

    // req0 alone once so req1 holds priority, then an 8-beat req1 PutFullData.
    set_req(1, 1'b0, 3'd4, 3'd3, 2'd2, 32'h200);
    cycle();
    set_req(1, 1'b1, 3'd0, 3'd6, 2'd3, 32'h300);
    for (int b = 0; b < 8; b++) begin
      #1;
      chk("burst owner", a_source[2], 1'b1);
      chk("burst req0 blocked", rq_a_ready[0], 1'b0);
      cycle();
    end
    #1 chk("burst released", a_source[2], 1'b0);
    cycle();

    // Stall for 5 cycles with req1 arriving in cycle 2: fields must stay on req0.
    set_req(1, 1'b0, 3'd4, 3'd3, 2'd0, 32'h0);
    set_req(0, 1'b1, 3'd4, 3'd3, 2'd2, 32'hA0);
    a_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c == 1) set_req(1, 1'b1, 3'd4, 3'd3, 2'd1, 32'hB0);
      #1;
      chk("stall addr stable", a_address, 32'hA0);
      chk("stall source stable", a_source, 3'b010);
      cycle();
    end
    a_ready = 1'b1;
    #1 chk("stall req0 fires first", rq_a_ready, 2'b01);
    cycle();

    // Reset during beat 3 of a 4-beat burst, then req1 served normally.
    do_reset();
    set_req(0, 1'b1, 3'd0, 3'd5, 2'd0, 32'hC0);
    set_req(1, 1'b1, 3'd4, 3'd3, 2'd3, 32'hD0);
    cycle();
    cycle();
    #1 chk("beat3 present", a_source, 3'b000);
    do_reset();
    set_req(0, 1'b0, 3'd0, 3'd5, 2'd0, 32'hC0);
    #1 chk("post-reset grant", a_source, 3'b111);
    cycle();

    // Single-beat cases: PutFullData size 2 and Get size 6 each release immediately.
    set_req(0, 1'b1, 3'd0, 3'd2, 2'd1, 32'hE0);
    #1 chk("put s2 winner", a_source[2], 1'b0);
    cycle();
    #1 chk("after put s2", a_source[2], 1'b1);
    cycle();
    set_req(0, 1'b1, 3'd4, 3'd6, 2'd1, 32'hF0);
    #1 chk("get s6 winner", a_source[2], 1'b0);
    cycle();
    #1 chk("after get s6", a_source[2], 1'b1);
    cycle();

    // D routing table.
    dt[0] = '{1'b1, 3'b101, 2'b10, 2'b10, 2'b01, 1'b1};
    dt[1] = '{1'b1, 3'b101, 2'b01, 2'b10, 2'b01, 1'b0};
    dt[2] = '{1'b1, 3'b010, 2'b01, 2'b01, 2'b10, 1'b1};
    dt[3] = '{1'b0, 3'b111, 2'b11, 2'b00, 2'b11, 1'b1};
    dt[4] = '{1'b1, 3'b000, 2'b10, 2'b01, 2'b00, 1'b0};
    dt[5] = '{1'b1, 3'b110, 2'b11, 2'b10, 2'b10, 1'b1};
    for (int k = 0; k < 6; k++) begin
      d_valid = dt[k].dv; d_source = dt[k].ds; rq_d_ready = dt[k].rdy;
      #1;
      chk("dtab rq_d_valid", rq_d_valid, dt[k].e_v);
      chk("dtab rq_d_source", rq_d_source[dt[k].ds[2]], dt[k].e_src);
      chk("dtab d_ready", d_ready, dt[k].e_rdy);
      @(negedge clk);
    end

    // Random traffic on both channels against the model.
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 2; i++) begin
        set_req(i, ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 5)),
                3'($urandom_range(0, 7)), 2'($urandom), $urandom);
      end
      a_ready = ($urandom_range(0, 3) != 0);
      d_valid = 1'($urandom); d_source = 3'($urandom); rq_d_ready = 2'($urandom);
      d_opcode = 3'($urandom); d_data = {$urandom, $urandom};
      if ($urandom_range(0, 499) == 0) do_reset();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
